// File: rtl/simple_axi_write_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | simple_axi_write_arbiter_pkg                                         |
// | State encoding and ptr-width helper for the write arbiter.           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package simple_axi_write_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOCK = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // Width of a requester index; never less than one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/simple_axi_write_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick                                                              |
// | Round-robin winner: first request at or above ptr, wrapping.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_pick
  import simple_axi_write_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] win_o,
  output logic [IDX_W-1:0] win_idx_o
);

  localparam logic [IDX_W:0] C_N_REQ = (IDX_W+1)'(N_REQ);

  logic             found;
  logic [IDX_W:0]   cand;

  always_comb begin
    win_o     = '0;
    win_idx_o = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr_i} + (IDX_W+1)'(k);
      if (cand >= C_N_REQ) begin
        cand = cand - C_N_REQ;
      end
      if (!found && req_i[cand[IDX_W-1:0]]) begin
        found                     = 1'b1;
        win_o[cand[IDX_W-1:0]]    = 1'b1;
        win_idx_o                 = cand[IDX_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/simple_axi_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | simple_axi_write_arbiter                                             |
// | Locked round-robin arbiter of N simple-AXI writers onto one bridge.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module simple_axi_write_arbiter
  import simple_axi_write_arbiter_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int LEN_W      = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [N_REQ-1:0]               r_wvalid_i,
  output logic [N_REQ-1:0]               r_wready_o,
  input  logic [N_REQ*AXI_ADDR_W-1:0]    r_waddr_i,
  input  logic [N_REQ*AXI_DATA_W-1:0]    r_wdata_i,
  input  logic [N_REQ*AXI_DATA_W/8-1:0]  r_wstrb_i,
  input  logic [N_REQ*LEN_W-1:0]         r_wlen_i,
  output logic [N_REQ-1:0]               r_wlast_o,
  output logic                           m_wvalid_o,
  input  logic                           m_wready_i,
  output logic [AXI_ADDR_W-1:0]          m_waddr_o,
  output logic [AXI_DATA_W-1:0]          m_wdata_o,
  output logic [AXI_DATA_W/8-1:0]        m_wstrb_o,
  output logic [LEN_W-1:0]               m_wlen_o,
  input  logic                           m_wlast_i,
  output logic [N_REQ-1:0]               grant_o,
  output logic                           busy_o
);

  localparam int IDX_W  = ptr_width(N_REQ);
  localparam int STRB_W = AXI_DATA_W / 8;
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(N_REQ - 1);

  logic [1:0]       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] ptr_q,   ptr_d;

  logic [N_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic             in_lock;
  logic             xfer_done;

  logic [AXI_ADDR_W-1:0] req_addr [N_REQ];
  logic [AXI_DATA_W-1:0] req_data [N_REQ];
  logic [STRB_W-1:0]     req_strb [N_REQ];
  logic [LEN_W-1:0]      req_len  [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
    assign req_addr[gi] = r_waddr_i[gi*AXI_ADDR_W +: AXI_ADDR_W];
    assign req_data[gi] = r_wdata_i[gi*AXI_DATA_W +: AXI_DATA_W];
    assign req_strb[gi] = r_wstrb_i[gi*STRB_W     +: STRB_W];
    assign req_len[gi]  = r_wlen_i [gi*LEN_W      +: LEN_W];
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i     (r_wvalid_i),
    .ptr_i     (ptr_q),
    .win_o     (pick_onehot),
    .win_idx_o (pick_idx)
  );

  assign in_lock = (state_q == ST_LOCK);

  // Outside LOCK grant_q is zero, so the AND-OR mux yields all-zero m_*.
  always_comb begin
    m_wvalid_o = 1'b0;
    m_waddr_o  = '0;
    m_wdata_o  = '0;
    m_wstrb_o  = '0;
    m_wlen_o   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (in_lock && grant_q[i]) begin
        m_wvalid_o = m_wvalid_o | r_wvalid_i[i];
        m_waddr_o  = m_waddr_o  | req_addr[i];
        m_wdata_o  = m_wdata_o  | req_data[i];
        m_wstrb_o  = m_wstrb_o  | req_strb[i];
        m_wlen_o   = m_wlen_o   | req_len[i];
      end
    end
  end

  assign r_wready_o = in_lock ? (grant_q & {N_REQ{m_wready_i}}) : '0;
  assign r_wlast_o  = in_lock ? (grant_q & {N_REQ{m_wlast_i}})  : '0;
  assign grant_o    = grant_q;
  assign busy_o     = (state_q != ST_IDLE);

  assign xfer_done = in_lock & m_wvalid_o & m_wready_i & m_wlast_i;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (|r_wvalid_i) begin
          grant_d = pick_onehot;
          owner_d = pick_idx;
          state_d = ST_LOCK;
        end
      end
      ST_LOCK: begin
        if (xfer_done) begin
          grant_d = '0;
          state_d = ST_GAP;
          ptr_d   = (owner_q == C_LAST_IDX) ? '0 : owner_q + IDX_W'(1);
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_simple_axi_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_simple_axi_write_arbiter                                          |
// | Directed bench with a transaction-level arbitration model.           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_simple_axi_write_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int LW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    wvalid = '0;
  logic [N*AW-1:0] waddr  = '0;
  logic [N*DW-1:0] wdata  = '0;
  logic [N*SW-1:0] wstrb  = '0;
  logic [N*LW-1:0] wlen   = '0;
  logic            m_wready = 1'b0;
  logic            m_wlast  = 1'b0;

  logic [N-1:0]    r_wready, r_wlast, grant;
  logic            m_wvalid, busy;
  logic [AW-1:0]   m_waddr;
  logic [DW-1:0]   m_wdata;
  logic [SW-1:0]   m_wstrb;
  logic [LW-1:0]   m_wlen;

  always #5 clk = ~clk;

  simple_axi_write_arbiter #(
    .N_REQ(N), .AXI_ADDR_W(AW), .AXI_DATA_W(DW), .LEN_W(LW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .r_wvalid_i(wvalid), .r_wready_o(r_wready),
    .r_waddr_i(waddr), .r_wdata_i(wdata), .r_wstrb_i(wstrb), .r_wlen_i(wlen),
    .r_wlast_o(r_wlast),
    .m_wvalid_o(m_wvalid), .m_wready_i(m_wready),
    .m_waddr_o(m_waddr), .m_wdata_o(m_wdata), .m_wstrb_o(m_wstrb), .m_wlen_o(m_wlen),
    .m_wlast_i(m_wlast),
    .grant_o(grant), .busy_o(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the bridge, whether we are in the switch bubble, and the rotation start.
  int mdl_owner = -1;
  bit mdl_gap   = 1'b0;
  int mdl_ptr   = 0;
  bit chk_en    = 1'b0;

  function automatic int first_from(input logic [N-1:0] req, input int p);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p + k) % N;
      if (req[j[1:0]]) return j;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mdl_owner = -1;
      mdl_gap   = 1'b0;
      mdl_ptr   = 0;
    end else if (mdl_gap) begin
      mdl_gap = 1'b0;
    end else if (mdl_owner < 0) begin
      mdl_owner = first_from(wvalid, mdl_ptr);
    end else if (wvalid[mdl_owner[1:0]] && m_wready && m_wlast) begin
      mdl_ptr   = (mdl_owner + 1) % N;
      mdl_owner = -1;
      mdl_gap   = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [N-1:0]  e_grant, e_rdy, e_lst;
      logic          e_valid;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_data;
      logic [SW-1:0] e_strb;
      logic [LW-1:0] e_len;
      e_grant = '0; e_rdy = '0; e_lst = '0; e_valid = 1'b0;
      e_addr = '0; e_data = '0; e_strb = '0; e_len = '0;
      if (mdl_owner >= 0) begin
        e_grant = N'(1) << mdl_owner;
        e_valid = wvalid[mdl_owner[1:0]];
        e_addr  = waddr[mdl_owner*AW +: AW];
        e_data  = wdata[mdl_owner*DW +: DW];
        e_strb  = wstrb[mdl_owner*SW +: SW];
        e_len   = wlen [mdl_owner*LW +: LW];
        if (m_wready) e_rdy = e_grant;
        if (m_wlast)  e_lst = e_grant;
      end
      check("mdl_grant",   64'(grant),    64'(e_grant));
      check("mdl_busy",    64'(busy),     64'((mdl_owner >= 0) || mdl_gap));
      check("mdl_m_valid", 64'(m_wvalid), 64'(e_valid));
      check("mdl_m_addr",  64'(m_waddr),  64'(e_addr));
      check("mdl_m_data",  64'(m_wdata),  64'(e_data));
      check("mdl_m_strb",  64'(m_wstrb),  64'(e_strb));
      check("mdl_m_len",   64'(m_wlen),   64'(e_len));
      check("mdl_r_ready", 64'(r_wready), 64'(e_rdy));
      check("mdl_r_last",  64'(r_wlast),  64'(e_lst));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic serve(input int beats, output int owner);
    int w;
    owner = -1;
    m_wready = 1'b1;
    m_wlast  = 1'b0;
    w = 0;
    while (grant == '0 && w < 20) begin
      tick();
      w++;
    end
    if (grant == '0) begin
      n_tests++;
      n_fail++;
      $display("FAIL serve_timeout: got no grant within 20 cycles, expected a grant");
    end else begin
      for (int i = 0; i < N; i++) if (grant[i]) owner = i;
      for (int b = 1; b <= beats; b++) begin
        m_wlast = (b == beats);
        tick();
      end
      m_wlast = 1'b0;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] gseq [4];
    int order [8];
    int exp_order [8];
    int own;
    int beats_seen;

    for (int i = 0; i < N; i++) begin
      waddr[i*AW +: AW] = 32'h1000_0000 + 32'(i * 32'h100);
      wdata[i*DW +: DW] = 32'hD00D_0000 + 32'(i);
      wstrb[i*SW +: SW] = 4'hF ^ 4'(i);
      wlen [i*LW +: LW] = 8'(16 + 4 * i);
    end

    // Reset state
    rst = 1'b1;
    tick();
    chk_en   = 1'b1;
    m_wready = 1'b1;
    m_wlast  = 1'b1;
    wvalid   = 4'b1111;
    tick();
    check("rst_grant",   64'(grant),    64'd0);
    check("rst_busy",    64'(busy),     64'd0);
    check("rst_m_valid", 64'(m_wvalid), 64'd0);
    check("rst_r_ready", 64'(r_wready), 64'd0);
    check("rst_r_last",  64'(r_wlast),  64'd0);
    wvalid = '0; m_wready = 1'b0; m_wlast = 1'b0;
    rst = 1'b0;
    tick();

    // Single request, 4 beats, bridge always ready
    wvalid = 4'b0001; m_wready = 1'b1; m_wlast = 1'b0;
    tick();
    beats_seen = 0;
    for (int b = 1; b <= 4; b++) begin
      m_wlast = (b == 4);
      #1;
      check("single_grant", 64'(grant), 64'd1);
      check("single_len",   64'(m_wlen), 64'd16);
      if (m_wvalid && m_wready) beats_seen++;
      tick();
    end
    check("single_beats", 64'(beats_seen), 64'd4);
    m_wlast = 1'b0; wvalid = '0;
    #1;
    check("single_gap_busy",  64'(busy),  64'd1);
    check("single_gap_grant", 64'(grant), 64'd0);
    tick();
    check("single_busy_fall", 64'(busy), 64'd0);

    // Simultaneous requests at ptr=0
    do_reset();
    wvalid = 4'b0011; m_wready = 1'b1; m_wlast = 1'b1;
    tick(); gseq[0] = grant;
    tick(); wvalid = 4'b0010; #1; gseq[1] = grant;
    tick(); gseq[2] = grant;
    tick(); gseq[3] = grant;
    tick();
    wvalid = '0; m_wlast = 1'b0;
    tick();
    check("simul_g0", 64'(gseq[0]), 64'd1);
    check("simul_g1", 64'(gseq[1]), 64'd0);
    check("simul_g2", 64'(gseq[2]), 64'd0);
    check("simul_g3", 64'(gseq[3]), 64'd2);

    // Lock hold while requester 1 waits, including owner dropping valid
    wvalid = 4'b0001; m_wready = 1'b1; m_wlast = 1'b0;
    tick();
    wvalid = 4'b0011;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("lock_grant",  64'(grant), 64'd1);
      check("lock_rdy1",   64'(r_wready[1]), 64'd0);
      tick();
    end
    wvalid = 4'b0010;
    #1;
    check("lock_drop_grant", 64'(grant),    64'd1);
    check("lock_drop_valid", 64'(m_wvalid), 64'd0);
    tick();
    wvalid = 4'b0011; m_wlast = 1'b1;
    #1;
    check("lock_last_rdy1", 64'(r_wready[1]), 64'd0);
    tick();
    m_wlast = 1'b0; wvalid = 4'b0010;
    #1;
    check("lock_gap_grant", 64'(grant), 64'd0);
    tick();
    tick();
    check("lock_next_grant", 64'(grant), 64'd2);
    m_wlast = 1'b1;
    tick();
    m_wlast = 1'b0; wvalid = '0;
    tick();

    // Backpressure with last held high
    wvalid = 4'b0100; m_wready = 1'b1; m_wlast = 1'b0;
    tick();
    tick();
    m_wready = 1'b0; m_wlast = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_grant", 64'(grant), 64'd4);
      check("bp_busy",  64'(busy),  64'd1);
      tick();
    end
    m_wready = 1'b1;
    #1;
    check("bp_ready_route", 64'(r_wready), 64'd4);
    tick();
    m_wlast = 1'b0; wvalid = '0;
    #1;
    check("bp_exit_grant", 64'(grant), 64'd0);
    tick();

    // Reset in the middle of a transfer
    wvalid = 4'b0001; m_wready = 1'b1; m_wlast = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; wvalid = 4'b1010;
    #1;
    check("rstlock_grant", 64'(grant),    64'd0);
    check("rstlock_valid", 64'(m_wvalid), 64'd0);
    check("rstlock_busy",  64'(busy),     64'd0);
    tick();
    check("rstlock_regrant_ptr0", 64'(grant), 64'd2);
    m_wlast = 1'b1;
    tick();
    m_wlast = 1'b0; wvalid = '0;
    tick();

    // Fairness with all four requesting continuously
    do_reset();
    wvalid = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      serve(2, own);
      order[t] = own;
    end
    wvalid = '0;
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
    for (int t = 0; t < 8; t++) begin
      check("fair_order", 64'(order[t]), 64'(exp_order[t]));
    end
    tick();
    tick();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
